// File: rtl/conv_a2_pkg.sv
// Shared types and sizing helpers for the ConvA2 parameter loader.
// The loader FSM encoding and the weight-bank depth formula live here.
package conv_a2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_IDLE = 3'd1,
    LOAD_WM   = 3'd2,
    LOAD_BM   = 3'd3,
    CHECK     = 3'd4,
    LOADED    = 3'd5
  } load_state_e;

  // Words per weight bank: every filter's kernel slice for this unit's share of the IFM depth.
  function automatic int calc_wm_depth(input int kernal_size, input int number_of_filters,
                                       input int ifm_depth, input int number_of_units);
    return kernal_size * kernal_size * number_of_filters * (ifm_depth / number_of_units + 1);
  endfunction

  function automatic int bank_idx_bits(input int number_of_units);
    return (number_of_units > 1) ? $clog2(number_of_units) : 1;
  endfunction

  function automatic int word_cnt_bits(input int wm_depth, input int number_of_filters);
    int span;
    span = (wm_depth > number_of_filters) ? wm_depth : number_of_filters;
    return (span > 1) ? $clog2(span) : 1;
  endfunction

  localparam int DEFAULT_WM_DEPTH = calc_wm_depth(5, 120, 16, 3);

endpackage

// File: rtl/conv_a2_load_ctrl_if.sv
// Valid/ready parameter-word stream from the RISC-V side into the ConvA2 loader.
// master = word source, slave = loader.
interface conv_a2_load_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/conv_a2_load_addr_gen.sv
// Word counter and bank index for the weight/bias write sequence, with wrap and
// last-word flags consumed by the loader FSM.
module conv_a2_load_addr_gen
  import conv_a2_pkg::*;
#(
  parameter int WM_DEPTH          = DEFAULT_WM_DEPTH,
  parameter int NUMBER_OF_FILTERS = 120,
  parameter int NUMBER_OF_UNITS   = 3,
  parameter int CNT_W             = word_cnt_bits(WM_DEPTH, NUMBER_OF_FILTERS),
  parameter int BANK_W            = bank_idx_bits(NUMBER_OF_UNITS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              step_wm,
  input  logic              step_bm,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [BANK_W-1:0] bank,
  output logic              last_wm_word,
  output logic              last_bm_word
);

  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic              last_bank_word;

  assign last_bank_word = (word_cnt_q == CNT_W'(WM_DEPTH - 1));
  assign last_wm_word   = last_bank_word && (bank_q == BANK_W'(NUMBER_OF_UNITS - 1));
  assign last_bm_word   = (word_cnt_q == CNT_W'(NUMBER_OF_FILTERS - 1));

  always_comb begin
    word_cnt_d = word_cnt_q;
    bank_d     = bank_q;
    if (restart) begin
      word_cnt_d = '0;
      bank_d     = '0;
    end else if (step_wm) begin
      if (last_bank_word) begin
        // Bank change and WM->BM change both restart the word counter.
        word_cnt_d = '0;
        bank_d     = last_wm_word ? '0 : bank_q + 1'b1;
      end else begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
    end else if (step_bm) begin
      word_cnt_d = last_bm_word ? '0 : word_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt_q <= '0;
      bank_q     <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      bank_q     <= bank_d;
    end
  end

  assign word_cnt = word_cnt_q;
  assign bank     = bank_q;

endmodule

// File: rtl/conv_a2_load_ctrl.sv
// ConvA2 parameter loader: streams weights then biases into the layer memories and
// gates the layer start until loaded. Optional trailing checksum: CONVA2_LOAD_CHECKSUM_EN.
module conv_a2_load_ctrl
  import conv_a2_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDRESS_BITS      = 15,
  parameter int IFM_DEPTH         = 16,
  parameter int KERNAL_SIZE       = 5,
  parameter int NUMBER_OF_FILTERS = 120,
  parameter int NUMBER_OF_UNITS   = 3,
  parameter int WM_DEPTH          = calc_wm_depth(KERNAL_SIZE, NUMBER_OF_FILTERS,
                                                  IFM_DEPTH, NUMBER_OF_UNITS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_req,
  input  logic                       layer_busy,
  conv_a2_load_ctrl_if.slave         s,
  input  logic                       start_from_previous,
  output logic                       start_to_layer,
  output logic [DATA_WIDTH-1:0]      riscv_data,
  output logic [ADDRESS_BITS-1:0]    riscv_address,
  output logic [NUMBER_OF_UNITS-1:0] wm_enable_write,
  output logic                       bm_enable_write,
  output logic                       loaded,
  output logic                       load_error
);

  localparam int CNT_W  = word_cnt_bits(WM_DEPTH, NUMBER_OF_FILTERS);
  localparam int BANK_W = bank_idx_bits(NUMBER_OF_UNITS);

  load_state_e state_q, state_d;

  logic                       ready;
  logic                       accept;
  logic                       restart;
  logic                       step_wm;
  logic                       step_bm;
  logic [CNT_W-1:0]           word_cnt;
  logic [BANK_W-1:0]          bank;
  logic                       last_wm_word;
  logic                       last_bm_word;
  logic [NUMBER_OF_UNITS-1:0] bank_onehot;

  logic [DATA_WIDTH-1:0]      riscv_data_q, riscv_data_d;
  logic [ADDRESS_BITS-1:0]    riscv_address_q, riscv_address_d;
  logic [NUMBER_OF_UNITS-1:0] wm_en_q, wm_en_d;
  logic                       bm_en_q, bm_en_d;

`ifdef CONVA2_LOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]      sum_q, sum_d;
  logic                       load_error_q, load_error_d;
  logic                       set_error;
`endif

  conv_a2_load_addr_gen #(
    .WM_DEPTH          (WM_DEPTH),
    .NUMBER_OF_FILTERS (NUMBER_OF_FILTERS),
    .NUMBER_OF_UNITS   (NUMBER_OF_UNITS),
    .CNT_W             (CNT_W),
    .BANK_W            (BANK_W)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .restart      (restart),
    .step_wm      (step_wm),
    .step_bm      (step_bm),
    .word_cnt     (word_cnt),
    .bank         (bank),
    .last_wm_word (last_wm_word),
    .last_bm_word (last_bm_word)
  );

  for (genvar gi = 0; gi < NUMBER_OF_UNITS; gi++) begin : g_bank_dec
    assign bank_onehot[gi] = (bank == BANK_W'(gi));
  end

  assign ready   = (state_q == LOAD_WM) || (state_q == LOAD_BM) || (state_q == CHECK);
  assign accept  = s.s_valid && ready;
  assign step_wm = accept && (state_q == LOAD_WM);
  assign step_bm = accept && (state_q == LOAD_BM);

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
`ifdef CONVA2_LOAD_CHECKSUM_EN
    set_error = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d = WAIT_IDLE;
          restart = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (!layer_busy) state_d = LOAD_WM;
      end
      LOAD_WM: begin
        if (step_wm && last_wm_word) state_d = LOAD_BM;
      end
      LOAD_BM: begin
        if (step_bm && last_bm_word) begin
`ifdef CONVA2_LOAD_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = LOADED;
`endif
        end
      end
`ifdef CONVA2_LOAD_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          if (s.s_data == sum_q) begin
            state_d = LOADED;
          end else begin
            state_d   = IDLE;
            set_error = 1'b1;
          end
        end
      end
`endif
      LOADED: begin
        if (load_req) begin
          state_d = WAIT_IDLE;
          restart = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write port: data/address hold between writes; strobes last exactly one cycle.
  always_comb begin
    riscv_data_d    = riscv_data_q;
    riscv_address_d = riscv_address_q;
    wm_en_d         = '0;
    bm_en_d         = 1'b0;
    if (step_wm || step_bm) begin
      riscv_data_d    = s.s_data;
      riscv_address_d = ADDRESS_BITS'(word_cnt);
      wm_en_d         = step_wm ? bank_onehot : '0;
      bm_en_d         = step_bm;
    end
  end

`ifdef CONVA2_LOAD_CHECKSUM_EN
  always_comb begin
    sum_d        = sum_q;
    load_error_d = load_error_q;
    if (restart) begin
      sum_d        = '0;
      load_error_d = 1'b0;
    end else begin
      if (step_wm || step_bm) sum_d = sum_q + s.s_data;
      if (set_error) load_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q        <= '0;
      load_error_q <= 1'b0;
    end else begin
      sum_q        <= sum_d;
      load_error_q <= load_error_d;
    end
  end

  assign load_error = load_error_q;
`else
  assign load_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      riscv_data_q    <= '0;
      riscv_address_q <= '0;
      wm_en_q         <= '0;
      bm_en_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      riscv_data_q    <= riscv_data_d;
      riscv_address_q <= riscv_address_d;
      wm_en_q         <= wm_en_d;
      bm_en_q         <= bm_en_d;
    end
  end

  assign s.s_ready       = ready;
  assign loaded          = (state_q == LOADED);
  assign start_to_layer  = start_from_previous && (state_q == LOADED);
  assign riscv_data      = riscv_data_q;
  assign riscv_address   = riscv_address_q;
  assign wm_enable_write = wm_en_q;
  assign bm_enable_write = bm_en_q;

endmodule

// File: tb/tb_conv_a2_load_ctrl.sv
// Directed bench for conv_a2_load_ctrl with reduced sizes (2 banks x 4 words, 2 biases).
// Also exercises the trailing checksum word when CONVA2_LOAD_CHECKSUM_EN is defined.
module tb_conv_a2_load_ctrl;

  localparam int DW = 32;
  localparam int AW = 15;
  localparam int NU = 2;
  localparam int WMD = 4;
  localparam int NF = 2;
  localparam int TOTAL = NU * WMD + NF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_req = 1'b0;
  logic          layer_busy = 1'b0;
  logic          start_from_previous = 1'b0;
  logic          start_to_layer;
  logic [DW-1:0] riscv_data;
  logic [AW-1:0] riscv_address;
  logic [NU-1:0] wm_enable_write;
  logic          bm_enable_write;
  logic          loaded;
  logic          load_error;

  int checks = 0;
  int errors = 0;
  int load_k = 0;
  int load_sum = 0;

  conv_a2_load_ctrl_if #(.DATA_WIDTH(DW)) sif ();

  conv_a2_load_ctrl #(
    .DATA_WIDTH        (DW),
    .ADDRESS_BITS      (AW),
    .IFM_DEPTH         (2),
    .KERNAL_SIZE       (1),
    .NUMBER_OF_FILTERS (NF),
    .NUMBER_OF_UNITS   (NU)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .load_req            (load_req),
    .layer_busy          (layer_busy),
    .s                   (sif.slave),
    .start_from_previous (start_from_previous),
    .start_to_layer      (start_to_layer),
    .riscv_data          (riscv_data),
    .riscv_address       (riscv_address),
    .wm_enable_write     (wm_enable_write),
    .bm_enable_write     (bm_enable_write),
    .loaded              (loaded),
    .load_error          (load_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    load_k   = 0;
    load_sum = 0;
    checks++;
    if (loaded !== 1'b0 || sif.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL pulse_load: loaded=%0b s_ready=%0b required 0 0", loaded, sif.s_ready);
    end
  endtask

  // Streams n words first..first+n-1 with random gaps; checks every cycle's strobes.
  task automatic stream(input int n, input int first, input int gap_pct);
    int got = 0;
    int cyc = 0;
    int k;
    bit acc;
    logic [NU-1:0] exp_wm;
    logic          exp_bm;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_loaded;
    while (got < n && cyc < 400) begin
      sif.s_valid = ($urandom_range(99) >= gap_pct);
      sif.s_data  = DW'(first + got);
      acc = sif.s_valid && sif.s_ready;
      k = load_k;
      step();
      cyc++;
      checks++;
      if (acc) begin
        exp_wm   = (k < WMD) ? 2'b01 : (k < 2 * WMD) ? 2'b10 : 2'b00;
        exp_bm   = (k >= 2 * WMD);
        exp_addr = (k < 2 * WMD) ? AW'(k % WMD) : AW'(k - 2 * WMD);
        exp_data = DW'(first + got);
        load_k++;
        load_sum += first + got;
        got++;
`ifdef CONVA2_LOAD_CHECKSUM_EN
        exp_loaded = 1'b0;
`else
        exp_loaded = (load_k == TOTAL);
`endif
        if (wm_enable_write !== exp_wm || bm_enable_write !== exp_bm ||
            riscv_address !== exp_addr || riscv_data !== exp_data || loaded !== exp_loaded) begin
          errors++;
          $display("FAIL write k=%0d: wm=%b bm=%b addr=%0d data=%0d loaded=%b required wm=%b bm=%b addr=%0d data=%0d loaded=%b",
                   k, wm_enable_write, bm_enable_write, riscv_address, riscv_data, loaded,
                   exp_wm, exp_bm, exp_addr, exp_data, exp_loaded);
        end else begin
          $display("write k=%0d wm=%b bm=%b addr=%0d data=%0d", k, wm_enable_write,
                   bm_enable_write, riscv_address, riscv_data);
        end
      end else if (wm_enable_write !== '0 || bm_enable_write !== 1'b0) begin
        errors++;
        $display("FAIL idle_strobe: wm=%b bm=%b required 00 0", wm_enable_write, bm_enable_write);
      end
    end
    sif.s_valid = 1'b0;
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: accepted %0d required %0d", got, n);
    end
  endtask

`ifdef CONVA2_LOAD_CHECKSUM_EN
  task automatic send_check(input int word, input bit expect_ok);
    sif.s_valid = 1'b1;
    sif.s_data  = DW'(word);
    checks++;
    if (sif.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL check_ready: s_ready=%b required 1", sif.s_ready);
    end
    step();
    sif.s_valid = 1'b0;
    checks++;
    if (loaded !== expect_ok || load_error !== !expect_ok || wm_enable_write !== '0 ||
        bm_enable_write !== 1'b0 || sif.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL check_word %0d: loaded=%b load_error=%b wm=%b bm=%b s_ready=%b required loaded=%b load_error=%b strobes 0 s_ready 0",
               word, loaded, load_error, wm_enable_write, bm_enable_write, sif.s_ready,
               expect_ok, !expect_ok);
    end else begin
      $display("check word %0d loaded=%b load_error=%b", word, loaded, load_error);
    end
  endtask
`endif

  task automatic finish_load();
`ifdef CONVA2_LOAD_CHECKSUM_EN
    send_check(load_sum, 1'b1);
`endif
    checks++;
    if (loaded !== 1'b1 || load_error !== 1'b0 || sif.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL finish_load: loaded=%b load_error=%b s_ready=%b required 1 0 0",
               loaded, load_error, sif.s_ready);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (sif.s_ready !== 1'b0 || loaded !== 1'b0 || load_error !== 1'b0 ||
        wm_enable_write !== '0 || bm_enable_write !== 1'b0 ||
        riscv_data !== '0 || riscv_address !== '0 || start_to_layer !== 1'b0) begin
      errors++;
      $display("FAIL %s: s_ready=%b loaded=%b err=%b wm=%b bm=%b data=%0d addr=%0d start=%b required all 0",
               tag, sif.s_ready, loaded, load_error, wm_enable_write, bm_enable_write,
               riscv_data, riscv_address, start_to_layer);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    repeat (3) step();
    reset = 1'b0;
    check_all_zero("reset_state");
    step();
    check_all_zero("idle_after_reset");
    $display("test_reset done");
  endtask

  task automatic test_start_before_load();
    start_from_previous = 1'b1;
    #1;
    checks++;
    if (start_to_layer !== 1'b0) begin
      errors++;
      $display("FAIL start_before_load: start_to_layer=%b required 0", start_to_layer);
    end
    step();
    start_from_previous = 1'b0;
    $display("test_start_before_load start_to_layer=%b", start_to_layer);
  endtask

  task automatic test_basic_load();
    pulse_load();
    stream(TOTAL, 1, 0);
    finish_load();
    $display("test_basic_load done loaded=%b", loaded);
  endtask

  task automatic test_start_after_load();
    start_from_previous = 1'b1;
    #1;
    checks++;
    if (start_to_layer !== 1'b1) begin
      errors++;
      $display("FAIL start_after_load: start_to_layer=%b required 1", start_to_layer);
    end
    start_from_previous = 1'b0;
    #1;
    checks++;
    if (start_to_layer !== 1'b0) begin
      errors++;
      $display("FAIL start_released: start_to_layer=%b required 0", start_to_layer);
    end
    step();
    $display("test_start_after_load done");
  endtask

  task automatic test_layer_busy();
    reset = 1'b1;
    step();
    reset = 1'b0;
    layer_busy = 1'b1;
    pulse_load();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (sif.s_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_hold cycle %0d: s_ready=%b required 0", i, sif.s_ready);
      end
    end
    layer_busy = 1'b0;
    step();
    checks++;
    if (sif.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_release: s_ready=%b required 1", sif.s_ready);
    end
    stream(TOTAL, 21, 0);
    finish_load();
    $display("test_layer_busy done");
  endtask

  task automatic test_gaps_and_reset();
    pulse_load();
    stream(6, 1, 40);
    reset = 1'b1;
    step();
    check_all_zero("mid_load_reset");
    reset = 1'b0;
    step();
    check_all_zero("post_reset_idle");
    pulse_load();
    stream(TOTAL, 1, 35);
    finish_load();
    $display("test_gaps_and_reset done");
  endtask

  task automatic test_reload();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    load_k   = 0;
    load_sum = 0;
    checks++;
    if (loaded !== 1'b0) begin
      errors++;
      $display("FAIL reload_drop: loaded=%b required 0", loaded);
    end
    stream(TOTAL, 101, 0);
    finish_load();
    $display("test_reload done");
  endtask

`ifdef CONVA2_LOAD_CHECKSUM_EN
  task automatic test_checksum();
    pulse_load();
    stream(TOTAL, 1, 0);
    send_check(55, 1'b1);
    pulse_load();
    stream(TOTAL, 1, 0);
    send_check(54, 1'b0);
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    checks++;
    if (load_error !== 1'b0 || sif.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL error_clear: load_error=%b s_ready=%b required 0 0", load_error, sif.s_ready);
    end
    step();
    checks++;
    if (sif.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL retry_after_error: s_ready=%b required 1", sif.s_ready);
    end
    stream(TOTAL, 1, 0);
    finish_load();
    $display("test_checksum done");
  endtask
`endif

  initial begin
    test_reset();
    test_start_before_load();
    test_basic_load();
    test_start_after_load();
    test_layer_busy();
    test_gaps_and_reset();
    test_reload();
`ifdef CONVA2_LOAD_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
